// File: rtl/intra_mode_decision.sv
// 4x4 intra mode decision: accumulates DC and Planar SADs while an original block
// streams in, picks the cheaper mode, then streams out signed residual rows.
module intra_mode_decision #(
    parameter int PIX_W       = 8,
    parameter int SAD_W       = 12,
    parameter int DEFAULT_VAL = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blk_start,
    input  logic                   top_available,
    input  logic                   left_available,
    input  logic [4*PIX_W-1:0]     top_neighbors,
    input  logic [4*PIX_W-1:0]     left_neighbors,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic [4*PIX_W-1:0]     row_pixels,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*(PIX_W+1)-1:0] res_row,
    output logic [1:0]             res_row_idx,
    output logic                   res_last,
    output logic [7:0]             best_mode,
    output logic [SAD_W-1:0]       best_sad,
    output logic                   busy
);

    localparam int RES_W = PIX_W + 1;
    localparam int ACC_W = PIX_W + 4;
    localparam int SUM_W = PIX_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DECIDE, S_EMIT} state_t;

    state_t                  state_q, state_d;
    logic                    top_av_q, top_av_d, left_av_q, left_av_d;
    logic [4*PIX_W-1:0]      top_q, top_d, left_q, left_d;
    logic [4*PIX_W-1:0]      buf_q [4];
    logic [4*PIX_W-1:0]      buf_d [4];
    logic [1:0]              row_cnt_q, row_cnt_d;
    logic [SAD_W-1:0]        sad_dc_q, sad_dc_d, sad_pl_q, sad_pl_d;
    logic                    row_ready_q, row_ready_d, res_valid_q, res_valid_d;
    logic [4*RES_W-1:0]      res_row_q, res_row_d;
    logic [1:0]              res_idx_q, res_idx_d;
    logic                    res_last_q, res_last_d, busy_q, busy_d;
    logic [7:0]              best_mode_q, best_mode_d;
    logic [SAD_W-1:0]        best_sad_q, best_sad_d;

    logic [SUM_W-1:0]        nb_sum_s;
    logic [PIX_W-1:0]        dc_pred_s;
    logic                    planar_ok_s, decide_pl_s, emit_mode_s;
    logic [1:0]              emit_idx_s;
    logic [4*RES_W-1:0]      emit_row_s;
    logic [SAD_W-1:0]        row_sad_dc_s, row_sad_pl_s;

    // Planar predictor at (y,x); sum is at most 8*255+4, so ACC_W bits never overflow
    function automatic logic [PIX_W-1:0] planar_px(input logic [4*PIX_W-1:0] t,
                                                   input logic [4*PIX_W-1:0] l,
                                                   input logic [1:0] y, input logic [1:0] x);
        logic [ACC_W-1:0] acc;
        acc = ACC_W'(2'd3 - x) * ACC_W'(l[y*PIX_W +: PIX_W])
            + (ACC_W'(x) + ACC_W'(1'b1)) * ACC_W'(t[3*PIX_W +: PIX_W])
            + ACC_W'(2'd3 - y) * ACC_W'(t[x*PIX_W +: PIX_W])
            + (ACC_W'(y) + ACC_W'(1'b1)) * ACC_W'(l[3*PIX_W +: PIX_W])
            + ACC_W'(4'd4);
        return acc[PIX_W+2:3];
    endfunction

    function automatic logic [PIX_W-1:0] pixel_pred(input logic [4*PIX_W-1:0] t,
                                                    input logic [4*PIX_W-1:0] l,
                                                    input logic use_pl, input logic [PIX_W-1:0] dc,
                                                    input logic [1:0] y, input logic [1:0] x);
        logic [PIX_W-1:0] p;
        if (use_pl) begin
            p = planar_px(t, l, y, x);
        end else begin
            p = dc;
        end
        return p;
    endfunction

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        logic [PIX_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    // DC predictor, planar availability and per-row SAD contributions
    always_comb begin
        nb_sum_s = '0;
        for (int i = 0; i < 4; i++) begin
            if (top_av_q) begin
                nb_sum_s = nb_sum_s + SUM_W'(top_q[i*PIX_W +: PIX_W]);
            end else begin
                nb_sum_s = nb_sum_s;
            end
            if (left_av_q) begin
                nb_sum_s = nb_sum_s + SUM_W'(left_q[i*PIX_W +: PIX_W]);
            end else begin
                nb_sum_s = nb_sum_s;
            end
        end
        case ({top_av_q, left_av_q})
            2'b00:   dc_pred_s = PIX_W'(DEFAULT_VAL);
            2'b11:   dc_pred_s = nb_sum_s[SUM_W-1:3];
            default: dc_pred_s = nb_sum_s[PIX_W+1:2];
        endcase
        planar_ok_s  = top_av_q && left_av_q;
        decide_pl_s  = planar_ok_s && (sad_pl_q < sad_dc_q);
        row_sad_dc_s = '0;
        row_sad_pl_s = '0;
        for (int x = 0; x < 4; x++) begin
            row_sad_dc_s = row_sad_dc_s + SAD_W'(abs_diff(row_pixels[x*PIX_W +: PIX_W], dc_pred_s));
            row_sad_pl_s = row_sad_pl_s + SAD_W'(abs_diff(row_pixels[x*PIX_W +: PIX_W],
                pixel_pred(top_q, left_q, planar_ok_s, dc_pred_s, row_cnt_q, 2'(x))));
        end
    end

    // Residual row for the next beat: row 0 when leaving DECIDE, else the following row
    always_comb begin
        if (state_q == S_DECIDE) begin
            emit_idx_s  = 2'd0;
            emit_mode_s = decide_pl_s;
        end else begin
            emit_idx_s  = res_idx_q + 2'd1;
            emit_mode_s = best_mode_q[0];
        end
        emit_row_s = '0;
        for (int x = 0; x < 4; x++) begin
            emit_row_s[x*RES_W +: RES_W] = {1'b0, buf_q[emit_idx_s][x*PIX_W +: PIX_W]}
                - {1'b0, pixel_pred(top_q, left_q, emit_mode_s, dc_pred_s, emit_idx_s, 2'(x))};
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        top_av_d    = top_av_q;
        left_av_d   = left_av_q;
        top_d       = top_q;
        left_d      = left_q;
        buf_d       = buf_q;
        row_cnt_d   = row_cnt_q;
        sad_dc_d    = sad_dc_q;
        sad_pl_d    = sad_pl_q;
        row_ready_d = row_ready_q;
        res_valid_d = res_valid_q;
        res_row_d   = res_row_q;
        res_idx_d   = res_idx_q;
        res_last_d  = res_last_q;
        busy_d      = busy_q;
        best_mode_d = best_mode_q;
        best_sad_d  = best_sad_q;
        case (state_q)
            S_IDLE: begin
                if (blk_start) begin
                    top_av_d    = top_available;
                    left_av_d   = left_available;
                    top_d       = top_neighbors;
                    left_d      = left_neighbors;
                    row_cnt_d   = 2'd0;
                    sad_dc_d    = '0;
                    sad_pl_d    = '0;
                    best_mode_d = 8'h00;
                    best_sad_d  = '0;
                    row_ready_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (row_valid) begin
                    buf_d[row_cnt_q] = row_pixels;
                    sad_dc_d         = sad_dc_q + row_sad_dc_s;
                    sad_pl_d         = sad_pl_q + row_sad_pl_s;
                    row_cnt_d        = row_cnt_q + 2'd1;
                    if (row_cnt_q == 2'd3) begin
                        row_ready_d = 1'b0;
                        state_d     = S_DECIDE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DECIDE: begin
                best_mode_d = {7'd0, decide_pl_s};
                if (decide_pl_s) begin
                    best_sad_d = sad_pl_q;
                end else begin
                    best_sad_d = sad_dc_q;
                end
                res_valid_d = 1'b1;
                res_row_d   = emit_row_s;
                res_idx_d   = 2'd0;
                res_last_d  = 1'b0;
                state_d     = S_EMIT;
            end
            S_EMIT: begin
                if (res_ready && res_last_q) begin
                    res_valid_d = 1'b0;
                    res_row_d   = '0;
                    res_idx_d   = 2'd0;
                    res_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else if (res_ready) begin
                    res_row_d  = emit_row_s;
                    res_idx_d  = emit_idx_s;
                    res_last_d = (emit_idx_s == 2'd3);
                end else begin
                    state_d = S_EMIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            top_av_q    <= 1'b0;
            left_av_q   <= 1'b0;
            top_q       <= '0;
            left_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= '0;
            end
            row_cnt_q   <= 2'd0;
            sad_dc_q    <= '0;
            sad_pl_q    <= '0;
            row_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_row_q   <= '0;
            res_idx_q   <= 2'd0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            best_mode_q <= 8'h00;
            best_sad_q  <= '0;
        end else begin
            state_q     <= state_d;
            top_av_q    <= top_av_d;
            left_av_q   <= left_av_d;
            top_q       <= top_d;
            left_q      <= left_d;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= buf_d[i];
            end
            row_cnt_q   <= row_cnt_d;
            sad_dc_q    <= sad_dc_d;
            sad_pl_q    <= sad_pl_d;
            row_ready_q <= row_ready_d;
            res_valid_q <= res_valid_d;
            res_row_q   <= res_row_d;
            res_idx_q   <= res_idx_d;
            res_last_q  <= res_last_d;
            busy_q      <= busy_d;
            best_mode_q <= best_mode_d;
            best_sad_q  <= best_sad_d;
        end
    end

    assign row_ready   = row_ready_q;
    assign res_valid   = res_valid_q;
    assign res_row     = res_row_q;
    assign res_row_idx = res_idx_q;
    assign res_last    = res_last_q;
    assign best_mode   = best_mode_q;
    assign best_sad    = best_sad_q;
    assign busy        = busy_q;

endmodule
